// File: rtl/sram_pkg.sv
// Shared constants and the byte-lane merge used by both the write path and
// the port1 write-through path of the 1RW+1R SRAM model.
package sram_pkg;

  localparam int RDW_OLD    = 0;
  localparam int RDW_NEW    = 1;
  localparam int MAX_DATA_W = 256;

  // Lane i of the result comes from new_word when lane_mask[i] is set, else from old_word.
  function automatic logic [MAX_DATA_W-1:0] lane_merge(
    input logic [MAX_DATA_W-1:0] old_word,
    input logic [MAX_DATA_W-1:0] new_word,
    input logic [MAX_DATA_W-1:0] lane_mask,
    input int                    lane_w
  );
    logic [MAX_DATA_W-1:0] res;
    logic [7:0]            lane;
    res = old_word;
    for (int b = 0; b < MAX_DATA_W; b++) begin
      lane = 8'(b / lane_w);
      if (lane_mask[lane]) begin
        res[b] = new_word[b];
      end else begin
        res[b] = old_word[b];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/sram_rd_pipe.sv
// Read-latency pipeline for one SRAM read port: a {valid,data} shift register
// whose last stage holds the most recent read word between strobes.
module sram_rd_pipe #(
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk0,
  input  logic                  rst0,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dvalid
);

  logic                  valid_r [READ_LATENCY];
  logic [DATA_WIDTH-1:0] data_r  [READ_LATENCY];

  // Advance the pipe; data stages only move on a valid token so the tail holds the last read.
  always_ff @(posedge clk0) begin
    if (rst0) begin
      for (int k = 0; k < READ_LATENCY; k++) begin
        valid_r[k] <= 1'b0;
        data_r[k]  <= {DATA_WIDTH{1'b0}};
      end
    end else begin
      valid_r[0] <= rd_en;
      if (rd_en) begin
        data_r[0] <= rd_data;
      end
      for (int k = 1; k < READ_LATENCY; k++) begin
        valid_r[k] <= valid_r[k-1];
        if (valid_r[k-1]) begin
          data_r[k] <= data_r[k-1];
        end
      end
    end
  end

  assign dout   = data_r[READ_LATENCY-1];
  assign dvalid = valid_r[READ_LATENCY-1];

endmodule

// File: rtl/sram_1rw1r_wmask_model.sv
// Behavioural 1RW + 1R SRAM with per-lane write mask, configurable read latency
// and selectable read-during-write behaviour on the read-only port.
module sram_1rw1r_wmask_model
  import sram_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 10,
  parameter int NUM_WMASKS   = 4,
  parameter int READ_LATENCY = 1,
  parameter int RDW_MODE     = 0
) (
  input  logic                  clk0,
  input  logic                  rst0,
  input  logic                  csb0,
  input  logic                  web0,
  input  logic [NUM_WMASKS-1:0] wmask0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] din0,
  output logic [DATA_WIDTH-1:0] dout0,
  output logic                  dvalid0,
  input  logic                  csb1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  output logic [DATA_WIDTH-1:0] dout1,
  output logic                  dvalid1,
  output logic                  collide
);

  localparam int RAM_DEPTH = 1 << ADDR_WIDTH;
  localparam int LANE_W    = (NUM_WMASKS > 0) ? DATA_WIDTH / NUM_WMASKS : 1;

  if ((NUM_WMASKS < 1) || (DATA_WIDTH > MAX_DATA_W) || ((DATA_WIDTH % NUM_WMASKS) != 0) ||
      (READ_LATENCY < 1) || (READ_LATENCY > 3)) begin : g_bad_cfg
    $fatal(1, "sram_1rw1r_wmask_model: illegal DATA_WIDTH/NUM_WMASKS/READ_LATENCY");
  end

  logic [DATA_WIDTH-1:0] mem_r [RAM_DEPTH];
  logic                  wr_s;
  logic                  rd0_s;
  logic                  rd1_s;
  logic                  collide_s;
  logic                  collide_r;
  logic [DATA_WIDTH-1:0] merged_s;
  logic [DATA_WIDTH-1:0] rd1_data_s;

  assign wr_s      = ~csb0 & ~web0;
  assign rd0_s     = ~csb0 & web0;
  assign rd1_s     = ~csb1;
  assign collide_s = wr_s & rd1_s & (addr0 == addr1);
  assign merged_s  = DATA_WIDTH'(lane_merge(MAX_DATA_W'(mem_r[addr0]), MAX_DATA_W'(din0),
                                            MAX_DATA_W'(wmask0), LANE_W));

  // Port0 masked write; accesses sampled during reset are dropped and the array itself is never cleared.
  always_ff @(posedge clk0) begin
    if (!rst0 && wr_s) begin
      mem_r[addr0] <= merged_s;
    end
  end

  // Port1 read word: write-through mode forwards the merged word on a same-address collision.
  always_comb begin
    rd1_data_s = mem_r[addr1];
    if ((RDW_MODE == RDW_NEW) && collide_s) begin
      rd1_data_s = merged_s;
    end else begin
      rd1_data_s = mem_r[addr1];
    end
  end

  // One-cycle collision flag.
  always_ff @(posedge clk0) begin
    if (rst0) begin
      collide_r <= 1'b0;
    end else begin
      collide_r <= collide_s;
    end
  end

  assign collide = collide_r;

  sram_rd_pipe #(
    .DATA_WIDTH  (DATA_WIDTH),
    .READ_LATENCY(READ_LATENCY)
  ) u_pipe0 (
    .clk0   (clk0),
    .rst0   (rst0),
    .rd_en  (rd0_s),
    .rd_data(mem_r[addr0]),
    .dout   (dout0),
    .dvalid (dvalid0)
  );

  sram_rd_pipe #(
    .DATA_WIDTH  (DATA_WIDTH),
    .READ_LATENCY(READ_LATENCY)
  ) u_pipe1 (
    .clk0   (clk0),
    .rst0   (rst0),
    .rd_en  (rd1_s),
    .rd_data(rd1_data_s),
    .dout   (dout1),
    .dvalid (dvalid1)
  );

endmodule

// File: tb/tb_sram_1rw1r_wmask_model.sv
// Self-checking bench: three SRAM configurations driven in lockstep and compared
// every cycle against a queue-based reference model of the SRAM behaviour.
module tb_sram_1rw1r_wmask_model;

  typedef struct {
    int          due;
    logic [31:0] data;
  } pend_t;

  localparam int LAT [3] = '{1, 2, 3};
  localparam int RDW [3] = '{0, 1, 0};

  logic        clk0 = 1'b0;
  logic        rst0, csb0, web0, csb1;
  logic [3:0]  wmask0;
  logic [9:0]  addr0, addr1;
  logic [31:0] din0;
  logic [31:0] dout0_o [3];
  logic [31:0] dout1_o [3];
  logic        dv0_o [3];
  logic        dv1_o [3];
  logic        col_o [3];

  logic [31:0] mem_m [1024];
  pend_t       pq [6][$];
  logic [31:0] e_dout [6];
  logic        e_dv [6];
  logic        e_col [3];
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;

  always #5 clk0 = ~clk0;

  sram_1rw1r_wmask_model #(.READ_LATENCY(1), .RDW_MODE(0)) u_d0 (
    .clk0(clk0), .rst0(rst0), .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0),
    .din0(din0), .dout0(dout0_o[0]), .dvalid0(dv0_o[0]), .csb1(csb1), .addr1(addr1),
    .dout1(dout1_o[0]), .dvalid1(dv1_o[0]), .collide(col_o[0]));

  sram_1rw1r_wmask_model #(.READ_LATENCY(2), .RDW_MODE(1)) u_d1 (
    .clk0(clk0), .rst0(rst0), .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0),
    .din0(din0), .dout0(dout0_o[1]), .dvalid0(dv0_o[1]), .csb1(csb1), .addr1(addr1),
    .dout1(dout1_o[1]), .dvalid1(dv1_o[1]), .collide(col_o[1]));

  sram_1rw1r_wmask_model #(.READ_LATENCY(3), .RDW_MODE(0)) u_d2 (
    .clk0(clk0), .rst0(rst0), .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0),
    .din0(din0), .dout0(dout0_o[2]), .dvalid0(dv0_o[2]), .csb1(csb1), .addr1(addr1),
    .dout1(dout1_o[2]), .dvalid1(dv1_o[2]), .collide(col_o[2]));

  function automatic logic [31:0] merge_m(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] m);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) begin
      if (m[i]) r[8*i +: 8] = n[8*i +: 8];
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Predict the outcome of the coming edge from the current inputs, apply it, compare.
  task automatic step(input logic r, input logic c0, input logic w0, input logic [3:0] m,
                      input logic [9:0] a0, input logic [31:0] d, input logic c1,
                      input logic [9:0] a1);
    logic        wr, rd0, rd1, col;
    logic [31:0] rdata;
    rst0 = r; csb0 = c0; web0 = w0; wmask0 = m; addr0 = a0; din0 = d; csb1 = c1; addr1 = a1;
    wr  = !c0 && !w0;
    rd0 = !c0 && w0;
    rd1 = !c1;
    col = wr && rd1 && (a0 == a1);
    for (int dd = 0; dd < 3; dd++) begin
      if (r) begin
        for (int p = 0; p < 2; p++) begin
          pq[2*dd+p].delete();
          e_dout[2*dd+p] = 32'h0;
          e_dv[2*dd+p]   = 1'b0;
        end
        e_col[dd] = 1'b0;
      end else begin
        e_col[dd] = col;
        if (rd0) pq[2*dd].push_back('{cyc + LAT[dd] - 1, mem_m[a0]});
        if (rd1) begin
          rdata = (col && RDW[dd] == 1) ? merge_m(mem_m[a1], d, m) : mem_m[a1];
          pq[2*dd+1].push_back('{cyc + LAT[dd] - 1, rdata});
        end
        for (int p = 0; p < 2; p++) begin
          e_dv[2*dd+p] = 1'b0;
          if (pq[2*dd+p].size() > 0 && pq[2*dd+p][0].due == cyc) begin
            e_dout[2*dd+p] = pq[2*dd+p][0].data;
            e_dv[2*dd+p]   = 1'b1;
            void'(pq[2*dd+p].pop_front());
          end
        end
      end
    end
    if (!r && wr) mem_m[a0] = merge_m(mem_m[a0], d, m);
    @(posedge clk0);
    #1;
    for (int dd = 0; dd < 3; dd++) begin
      check($sformatf("d%0d_dout0", dd), dout0_o[dd], e_dout[2*dd]);
      check($sformatf("d%0d_dvalid0", dd), 32'(dv0_o[dd]), 32'(e_dv[2*dd]));
      check($sformatf("d%0d_dout1", dd), dout1_o[dd], e_dout[2*dd+1]);
      check($sformatf("d%0d_dvalid1", dd), 32'(dv1_o[dd]), 32'(e_dv[2*dd+1]));
      check($sformatf("d%0d_collide", dd), 32'(col_o[dd]), 32'(e_col[dd]));
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b1, 4'h0, 10'h0, 32'h0, 1'b1, 10'h0);
  endtask

  initial begin
    logic [9:0] ra0;
    // reset for two cycles, then outputs stay zero while idle
    step(1'b1, 1'b1, 1'b1, 4'h0, 10'h0, 32'h0, 1'b1, 10'h0);
    step(1'b1, 1'b1, 1'b1, 4'h0, 10'h0, 32'h0, 1'b1, 10'h0);
    check("rst_dout1_const", dout1_o[2], 32'h0);
    idle(3);
    // masked write then port1 read
    step(1'b0, 1'b0, 1'b0, 4'hF, 10'h005, 32'hAABBCCDD, 1'b1, 10'h0);
    step(1'b0, 1'b0, 1'b0, 4'b0101, 10'h005, 32'h11223344, 1'b1, 10'h0);
    step(1'b0, 1'b1, 1'b1, 4'h0, 10'h0, 32'h0, 1'b0, 10'h005);
    check("mask_d0_dout1", dout1_o[0], 32'hAA22CC44);
    idle(3);
    // latency: port0 read of 0x3FF
    step(1'b0, 1'b0, 1'b0, 4'hF, 10'h3FF, 32'hDEADBEEF, 1'b1, 10'h0);
    step(1'b0, 1'b0, 1'b1, 4'h0, 10'h3FF, 32'h0, 1'b1, 10'h0);
    idle(1);
    check("lat3_not_yet", 32'(dv0_o[2]), 32'h0);
    idle(1);
    check("lat3_dvalid0", 32'(dv0_o[2]), 32'h1);
    check("lat3_dout0", dout0_o[2], 32'hDEADBEEF);
    idle(2);
    // collision on 0x010
    step(1'b0, 1'b0, 1'b0, 4'hF, 10'h010, 32'h0, 1'b1, 10'h0);
    step(1'b0, 1'b0, 1'b0, 4'hF, 10'h010, 32'h12345678, 1'b0, 10'h010);
    check("col_old_d0", dout1_o[0], 32'h0);
    check("col_flag_d0", 32'(col_o[0]), 32'h1);
    idle(1);
    check("col_new_d1", dout1_o[1], 32'h12345678);
    check("col_flag_clear", 32'(col_o[1]), 32'h0);
    idle(3);
    // reset mid-read on port1
    step(1'b0, 1'b1, 1'b1, 4'h0, 10'h0, 32'h0, 1'b0, 10'h005);
    step(1'b1, 1'b1, 1'b1, 4'h0, 10'h0, 32'h0, 1'b1, 10'h0);
    idle(3);
    check("rstmid_d1_dout1", dout1_o[1], 32'h0);
    // streaming writes with port1 reads lagging by two
    for (int i = 0; i < 18; i++) begin
      step(1'b0, (i < 16) ? 1'b0 : 1'b1, 1'b0, 4'hF, 10'(i % 16), 32'(i),
           (i >= 2) ? 1'b0 : 1'b1, 10'((i + 14) % 16));
    end
    idle(3);
    // randomized traffic over the initialised region
    for (int i = 0; i < 300; i++) begin
      ra0 = 10'($urandom_range(0, 15));
      step(($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0, 1'($urandom), 1'($urandom),
           4'($urandom), ra0, $urandom, 1'($urandom),
           ($urandom_range(0, 2) == 0) ? ra0 : 10'($urandom_range(0, 15)));
    end
    idle(4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
